vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

Parametrised VGA raster engine: pixel-tick divider, horizontal/vertical counters, sync and display-enable generation, and a selectable test-pattern source. It drives the board VGA connector directly and replaces the fixed 640x480 generator. It also serves downstream frame-buffer and text-overlay logic through a coordinate and pixel-data interface. All outputs are registered and aligned to one another.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal front porch, sync, back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical front porch, sync, back porch (lines)
- HS_POL / VS_POL, 0 / 0, active level of hsync / vsync
- CLK_DIV, 2, clk cycles per pixel tick (≥1)
- COLOR_W, 4, bits per colour channel
- CELL_W / CELL_H, 64 / 64, checkerboard cell size, power of two
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- i_mode  in  2  0 external, 1 checkerboard, 2 eight colour bars, 3 flat grey
- i_red / i_green / i_blue  in  COLOR_W each  external pixel for the coordinate shown one tick earlier
- o_x / o_y  out  $clog2(H_TOTAL) / $clog2(V_TOTAL)  current counter coordinate (stage 0)
- o_req  out  1  o_x/o_y lie inside the active area
- o_tick  out  1  pixel-tick strobe, one clk wide
- o_hsync / o_vsync  out  1  sync outputs, polarity per parameter
- o_de  out  1  display enable, aligned with colour
- o_red / o_green / o_blue  out  COLOR_W each  colour, forced to 0 when o_de=0
- o_frame_start  out  1  one-clk pulse at the tick where the counters reach (0,0)

## Operation
- Derived values: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL likewise. Line order is active, front porch, sync, back porch.
- The divider counts 0..CLK_DIV-1. o_tick is high on the clk where the count is CLK_DIV-1. With CLK_DIV=1, o_tick is constant 1 after reset.
- On each tick, x increments. At H_TOTAL-1, x wraps to 0 and y increments. At (H_TOTAL-1, V_TOTAL-1), both wrap to 0.
- Sync asserts when x ∈ [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC). The same rule applies to y.
- Pipeline has three stages, each advancing only on a tick:
  - Stage 0: the counters.
  - Stage 1: delayed copies of the sync, active and coordinate signals. i_* are sampled here.
  - Stage 2: output register.
- i_mode is latched only when a tick moves the counters to (0,0). Mode changes therefore never tear mid-frame.
- Patterns:
  - Checkerboard: white (all ones) where (x/CELL_W xor y/CELL_H) is odd, black otherwise.
  - Colour bars: bar = x*8/H_ACTIVE. Bit 2 drives red, bit 1 green, bit 0 blue, each at full scale.
  - Grey: MSB of each channel set, all other bits 0.
- Reset:
  - x, y, divider = 0.
  - o_hsync = ~HS_POL and o_vsync = ~VS_POL.
  - o_de = 0, colours = 0, o_frame_start = 0.
  - Latched mode = 0.
  - Pipeline stages are cleared to the inactive state.
- Reset asserted mid-frame restarts the frame on the next clk. The first post-reset frame is complete.

## Timing
- Latency: counter state to o_hsync/o_vsync/o_de/colour is 2 ticks.
- o_x/o_y/o_req are unregistered decodes of stage 0, so they lead the outputs by 2 ticks.
- External data contract: i_* must be valid on the tick after the tick where o_x/o_y showed the coordinate. A single registered RAM read satisfies this.
- Outputs change only on the clk edge following o_tick and hold for CLK_DIV clk cycles.
- o_frame_start is exactly one clk wide, including when CLK_DIV=1.

## Configuration
- VGA_TESTPAT_EN defined: the pattern generator and i_mode latch are compiled in.
- VGA_TESTPAT_EN undefined: i_mode is ignored and unconnected internally. Colour is always i_* gated by o_de. Latency and timing are unchanged.

## Structure
- Package vga_pkg holds:
  - mode enum (VGA_EXT, VGA_CHECKER, VGA_BARS, VGA_GREY);
  - 640x480@60 timing localparams;
  - bar colour constants.
- Sub-module vga_counter holds the divider plus x/y counters and tick/frame_start generation. The top level holds the sync decode, pipeline and pattern mux.

## Test plan
Benches use H=8/2/3/3 (H_TOTAL 16), V=4/1/2/1 (V_TOTAL 8), CLK_DIV=2 unless stated.
- Reset, then run 1 frame → o_hsync low for 3 ticks starting 2 ticks after x=10. Period is 32 clk. o_vsync low for 2 lines. o_frame_start pulses every 256 clk.
- HS_POL=1, VS_POL=1, CLK_DIV=1 → sync polarity inverted. o_tick stays high. Frame period is 128 clk.
- Mode 0, i_red = o_x registered by one tick → o_red outputs 0..7 on each active line. o_red = 0 whenever o_de = 0.
- Mode 1 with CELL_W=CELL_H=4 → row 0 shows pixels 0–3 black, 4–7 white. Row 4 is inverted.
- Mode switched 0→2 mid-frame → current frame unchanged. Next frame shows bars: pixel 0 black, pixel 7 white.
- rst pulsed at x=5, y=2 → next clk outputs at reset values. Counters restart from (0,0). o_frame_start fires 256 clk later.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA raster engine: pattern modes,
// 640x480@60 timing defaults and the colour-bar palette.
package vga_pkg;

    typedef enum logic [1:0] {
        VGA_EXT     = 2'd0,
        VGA_CHECKER = 2'd1,
        VGA_BARS    = 2'd2,
        VGA_GREY    = 2'd3
    } vga_mode_e;

    localparam int VGA640_H_ACTIVE = 640;
    localparam int VGA640_H_FP     = 16;
    localparam int VGA640_H_SYNC   = 96;
    localparam int VGA640_H_BP     = 48;
    localparam int VGA640_V_ACTIVE = 480;
    localparam int VGA640_V_FP     = 10;
    localparam int VGA640_V_SYNC   = 2;
    localparam int VGA640_V_BP     = 33;

    // {R,G,B} enables per bar, bar 7 in the top slice, bar 0 (black) at the bottom.
    localparam logic [23:0] BAR_RGB_TABLE = {
        3'b111, 3'b110, 3'b101, 3'b100,
        3'b011, 3'b010, 3'b001, 3'b000
    };

    function automatic logic [2:0] bar_rgb(input logic [2:0] bar);
        return BAR_RGB_TABLE[bar*3 +: 3];
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Coordinate/pixel-data port between the raster engine and downstream
// frame-buffer or overlay logic.
interface vga_timing_gen_if #(
    parameter int XW      = 10,
    parameter int YW      = 10,
    parameter int COLOR_W = 4
);
    // No handshake: o_x/o_y/o_req show the stage-0 coordinate every tick, and
    // the consumer must present i_* for that coordinate during the following tick.
    logic [XW-1:0]      o_x;
    logic [YW-1:0]      o_y;
    logic               o_req;
    logic [COLOR_W-1:0] i_red;
    logic [COLOR_W-1:0] i_green;
    logic [COLOR_W-1:0] i_blue;

    modport master (
        output o_x, o_y, o_req,
        input  i_red, i_green, i_blue
    );

    modport slave (
        input  o_x, o_y, o_req,
        output i_red, i_green, i_blue
    );
endinterface

// File: rtl/vga_counter.sv
// Pixel-tick divider and x/y raster counters (pipeline stage 0), plus the
// one-clk frame-start pulse and the wrap strobe used to latch the mode.
module vga_counter #(
    parameter int H_TOTAL = 800,
    parameter int V_TOTAL = 525,
    parameter int CLK_DIV = 2,
    parameter int XW      = 10,
    parameter int YW      = 10
) (
    input  logic          clk,
    input  logic          rst,
    output logic          o_tick,
    output logic          o_wrap,
    output logic          o_frame_start,
    output logic [XW-1:0] o_x,
    output logic [YW-1:0] o_y
);
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DW-1:0] r_div;
    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;
    logic          r_frame_start;
    logic          w_tick;
    logic          w_x_last;
    logic          w_y_last;

    // With CLK_DIV=1 the divider stays at 0, so the tick is permanently high.
    assign w_tick   = (r_div == DW'(CLK_DIV - 1));
    assign w_x_last = (r_x == XW'(H_TOTAL - 1));
    assign w_y_last = (r_y == YW'(V_TOTAL - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div         <= '0;
            r_x           <= '0;
            r_y           <= '0;
            r_frame_start <= 1'b0;
        end else begin
            r_div         <= w_tick ? '0 : r_div + DW'(1);
            r_frame_start <= w_tick && w_x_last && w_y_last;
            if (w_tick) begin
                if (w_x_last) begin
                    r_x <= '0;
                    r_y <= w_y_last ? '0 : r_y + YW'(1);
                end else begin
                    r_x <= r_x + XW'(1);
                end
            end
        end
    end

    assign o_tick        = w_tick;
    assign o_wrap        = w_tick && w_x_last && w_y_last;
    assign o_frame_start = r_frame_start;
    assign o_x           = r_x;
    assign o_y           = r_y;

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster engine: sync/DE decode, three-stage tick pipeline and
// colour source. Define VGA_TESTPAT_EN to compile in the test-pattern generator.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = VGA640_H_ACTIVE,
    parameter int H_FP     = VGA640_H_FP,
    parameter int H_SYNC   = VGA640_H_SYNC,
    parameter int H_BP     = VGA640_H_BP,
    parameter int V_ACTIVE = VGA640_V_ACTIVE,
    parameter int V_FP     = VGA640_V_FP,
    parameter int V_SYNC   = VGA640_V_SYNC,
    parameter int V_BP     = VGA640_V_BP,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int CLK_DIV  = 2,
    parameter int COLOR_W  = 4,
    parameter int CELL_W   = 64,
    parameter int CELL_H   = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         i_mode,
    vga_timing_gen_if.master   fb,
    output logic               o_tick,
    output logic               o_hsync,
    output logic               o_vsync,
    output logic               o_de,
    output logic [COLOR_W-1:0] o_red,
    output logic [COLOR_W-1:0] o_green,
    output logic [COLOR_W-1:0] o_blue,
    output logic               o_frame_start
);
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int XW       = $clog2(H_TOTAL);
    localparam int YW       = $clog2(V_TOTAL);
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;

    logic          w_tick;
    logic          w_wrap;
    logic          w_frame_start;
    logic [XW-1:0] w_x;
    logic [YW-1:0] w_y;
    logic          w_hs0;
    logic          w_vs0;
    logic          w_act0;

    vga_counter #(
        .H_TOTAL (H_TOTAL),
        .V_TOTAL (V_TOTAL),
        .CLK_DIV (CLK_DIV),
        .XW      (XW),
        .YW      (YW)
    ) u_counter (
        .clk           (clk),
        .rst           (rst),
        .o_tick        (w_tick),
        .o_wrap        (w_wrap),
        .o_frame_start (w_frame_start),
        .o_x           (w_x),
        .o_y           (w_y)
    );

    assign w_hs0  = (int'(w_x) >= HS_START) && (int'(w_x) < HS_END);
    assign w_vs0  = (int'(w_y) >= VS_START) && (int'(w_y) < VS_END);
    assign w_act0 = (int'(w_x) < H_ACTIVE) && (int'(w_y) < V_ACTIVE);

    assign fb.o_x   = w_x;
    assign fb.o_y   = w_y;
    assign fb.o_req = w_act0;

    // Stage 1: timing flags delayed one tick (sync flags are active-true here).
    logic r_hs1;
    logic r_vs1;
    logic r_act1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hs1  <= 1'b0;
            r_vs1  <= 1'b0;
            r_act1 <= 1'b0;
        end else if (w_tick) begin
            r_hs1  <= w_hs0;
            r_vs1  <= w_vs0;
            r_act1 <= w_act0;
        end
    end

    logic [COLOR_W-1:0] w_red;
    logic [COLOR_W-1:0] w_green;
    logic [COLOR_W-1:0] w_blue;

`ifdef VGA_TESTPAT_EN
    localparam int                 CX_SH   = $clog2(CELL_W);
    localparam int                 CY_SH   = $clog2(CELL_H);
    localparam logic [COLOR_W-1:0] C_FULL  = {COLOR_W{1'b1}};
    localparam logic [COLOR_W-1:0] C_GREY  = COLOR_W'(1) << (COLOR_W - 1);

    vga_mode_e     r_mode;
    logic [XW-1:0] r_x1;
    logic [YW-1:0] r_y1;
    logic [2:0]    w_bar;
    logic [2:0]    w_bar_en;
    logic          w_cell_odd;

    // Mode only changes on the tick that returns the counters to (0,0).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode <= VGA_EXT;
            r_x1   <= '0;
            r_y1   <= '0;
        end else begin
            if (w_wrap) begin
                r_mode <= vga_mode_e'(i_mode);
            end
            if (w_tick) begin
                r_x1 <= w_x;
                r_y1 <= w_y;
            end
        end
    end

    assign w_bar      = 3'((32'(r_x1) * 32'd8) / 32'(H_ACTIVE));
    assign w_bar_en   = bar_rgb(w_bar);
    assign w_cell_odd = r_x1[CX_SH] ^ r_y1[CY_SH];

    always_comb begin
        w_red   = fb.i_red;
        w_green = fb.i_green;
        w_blue  = fb.i_blue;
        unique case (r_mode)
            VGA_CHECKER: begin
                w_red   = w_cell_odd ? C_FULL : '0;
                w_green = w_cell_odd ? C_FULL : '0;
                w_blue  = w_cell_odd ? C_FULL : '0;
            end
            VGA_BARS: begin
                w_red   = w_bar_en[2] ? C_FULL : '0;
                w_green = w_bar_en[1] ? C_FULL : '0;
                w_blue  = w_bar_en[0] ? C_FULL : '0;
            end
            VGA_GREY: begin
                w_red   = C_GREY;
                w_green = C_GREY;
                w_blue  = C_GREY;
            end
            default: begin
                w_red   = fb.i_red;
                w_green = fb.i_green;
                w_blue  = fb.i_blue;
            end
        endcase
    end
`else
    logic w_unused_mode;

    assign w_unused_mode = ^i_mode;
    assign w_red         = fb.i_red;
    assign w_green       = fb.i_green;
    assign w_blue        = fb.i_blue;
`endif

    // Stage 2: output register; colour is blanked outside the active area.
    logic               r_hsync;
    logic               r_vsync;
    logic               r_de;
    logic [COLOR_W-1:0] r_red;
    logic [COLOR_W-1:0] r_green;
    logic [COLOR_W-1:0] r_blue;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hsync <= ~HS_POL;
            r_vsync <= ~VS_POL;
            r_de    <= 1'b0;
            r_red   <= '0;
            r_green <= '0;
            r_blue  <= '0;
        end else if (w_tick) begin
            r_hsync <= r_hs1 ? HS_POL : ~HS_POL;
            r_vsync <= r_vs1 ? VS_POL : ~VS_POL;
            r_de    <= r_act1;
            r_red   <= r_act1 ? w_red   : '0;
            r_green <= r_act1 ? w_green : '0;
            r_blue  <= r_act1 ? w_blue  : '0;
        end
    end

    assign o_tick        = w_tick;
    assign o_hsync       = r_hsync;
    assign o_vsync       = r_vsync;
    assign o_de          = r_de;
    assign o_red         = r_red;
    assign o_green       = r_green;
    assign o_blue        = r_blue;
    assign o_frame_start = w_frame_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a 16x8 raster: a position-indexed reference model
// predicts every output on every clk for two parameter sets.
module tb_vga_timing_gen;

    localparam int HT   = 16;
    localparam int VT   = 8;
    localparam int PPF  = HT * VT;
    localparam int MAXP = 2048;
`ifdef VGA_TESTPAT_EN
    localparam bit TESTPAT = 1'b1;
`else
    localparam bit TESTPAT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_a = 1'b1;
    logic       rst_b = 1'b1;
    logic [1:0] cur_mode = 2'd0;

    always #5 clk = ~clk;

    vga_timing_gen_if #(.XW(4), .YW(3), .COLOR_W(4)) fb_a ();
    vga_timing_gen_if #(.XW(4), .YW(3), .COLOR_W(4)) fb_b ();

    logic       tick_a, hs_a, vs_a, de_a, fs_a;
    logic [3:0] r_a, g_a, b_a;
    logic       tick_b, hs_b, vs_b, de_b, fs_b;
    logic [3:0] r_b, g_b, b_b;

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0), .CLK_DIV(2), .COLOR_W(4),
        .CELL_W(4), .CELL_H(4)
    ) dut_a (
        .clk(clk), .rst(rst_a), .i_mode(cur_mode), .fb(fb_a),
        .o_tick(tick_a), .o_hsync(hs_a), .o_vsync(vs_a), .o_de(de_a),
        .o_red(r_a), .o_green(g_a), .o_blue(b_a), .o_frame_start(fs_a)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .CLK_DIV(1), .COLOR_W(4),
        .CELL_W(4), .CELL_H(4)
    ) dut_b (
        .clk(clk), .rst(rst_b), .i_mode(cur_mode), .fb(fb_b),
        .o_tick(tick_b), .o_hsync(hs_b), .o_vsync(vs_b), .o_de(de_b),
        .o_red(r_b), .o_green(g_b), .o_blue(b_b), .o_frame_start(fs_b)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int which   = 0;
    int div     = 2;
    int j       = 0;
    bit hp      = 1'b0;
    bit vp      = 1'b0;

    logic [11:0] ext_hist  [MAXP];
    logic [1:0]  mode_hist [MAXP];

    task automatic do_reset();
        if (which == 0) rst_a = 1'b1;
        else            rst_b = 1'b1;
        @(posedge clk);
        #1;
        if (which == 0) rst_a = 1'b0;
        else            rst_b = 1'b0;
        j = 0;
    endtask

    // One clk: drive inputs, check every output against the model, record the
    // inputs that the DUT samples on this clk's tick.
    task automatic step(input int style);
        int p, q, qx, qy, f, bar;
        logic [3:0] r, g, b, er, eg, eb, full;
        logic [1:0] m;
        logic [11:0] ext;
        logic e_tick, e_fs, e_hs, e_vs, e_de, e_req;
        logic [12:0] exp_t, act_t;
        logic [11:0] exp_c, act_c;

        p = j / div;
        r = (style == 0) ? ((p >= 1) ? 4'((p - 1) % HT) : 4'd0) : 4'($urandom_range(0, 15));
        g = 4'($urandom_range(0, 15));
        b = 4'($urandom_range(0, 15));
        fb_a.i_red = r; fb_a.i_green = g; fb_a.i_blue = b;
        fb_b.i_red = r; fb_b.i_green = g; fb_b.i_blue = b;

        @(negedge clk);
        e_tick = ((j % div) == div - 1);
        e_fs   = ((j % div) == 0) && (p > 0) && ((p % PPF) == 0);
        e_req  = ((p % HT) < 8) && (((p / HT) % VT) < 4);
        q      = p - 2;
        full   = 4'hF;
        er = 4'd0; eg = 4'd0; eb = 4'd0;
        if (q < 0) begin
            e_hs = ~hp; e_vs = ~vp; e_de = 1'b0;
        end else begin
            qx   = q % HT;
            qy   = (q / HT) % VT;
            e_hs = (qx >= 10 && qx < 13) ? hp : ~hp;
            e_vs = (qy >= 5 && qy < 7) ? vp : ~vp;
            e_de = (qx < 8) && (qy < 4);
            if (e_de) begin
                f   = q / PPF;
                m   = (f == 0 || !TESTPAT) ? 2'd0 : mode_hist[f * PPF - 1];
                ext = ext_hist[q + 1];
                case (m)
                    2'd1: begin
                        if ((((qx / 4) ^ (qy / 4)) % 2) == 1) begin
                            er = full; eg = full; eb = full;
                        end
                    end
                    2'd2: begin
                        bar = qx * 8 / 8;
                        er = ((bar / 4) % 2 == 1) ? full : 4'd0;
                        eg = ((bar / 2) % 2 == 1) ? full : 4'd0;
                        eb = (bar % 2 == 1) ? full : 4'd0;
                    end
                    2'd3: begin
                        er = 4'd8; eg = 4'd8; eb = 4'd8;
                    end
                    default: begin
                        er = ext[11:8]; eg = ext[7:4]; eb = ext[3:0];
                    end
                endcase
            end
        end
        exp_t = {e_tick, e_fs, e_hs, e_vs, e_de, e_req, 4'(p % HT), 3'((p / HT) % VT)};
        exp_c = {er, eg, eb};
        if (which == 0) begin
            act_t = {tick_a, fs_a, hs_a, vs_a, de_a, fb_a.o_req, fb_a.o_x, fb_a.o_y};
            act_c = {r_a, g_a, b_a};
        end else begin
            act_t = {tick_b, fs_b, hs_b, vs_b, de_b, fb_b.o_req, fb_b.o_x, fb_b.o_y};
            act_c = {r_b, g_b, b_b};
        end
        n_tests++;
        if (act_t !== exp_t) begin
            n_fail++;
            $display("FAIL timing dut=%0d clk=%0d got tick,fs,hs,vs,de,req,x,y=%b want %b",
                     which, j, act_t, exp_t);
        end
        n_tests++;
        if (act_c !== exp_c) begin
            n_fail++;
            $display("FAIL colour dut=%0d clk=%0d got rgb=%h want %h", which, j, act_c, exp_c);
        end

        if ((j % div) == div - 1) begin
            ext_hist[p]  = {r, g, b};
            mode_hist[p] = cur_mode;
        end
        @(posedge clk);
        #1;
        j++;
    endtask

    task automatic run(input int n, input int style);
        for (int i = 0; i < n; i++) step(style);
    endtask

    task automatic use_dut_a();
        which = 0; div = 2; hp = 1'b0; vp = 1'b0;
    endtask

    task automatic test_reset();
        use_dut_a();
        cur_mode = 2'd0;
        do_reset();
        run(6, 1);
    endtask

    task automatic test_sync_timing();
        use_dut_a();
        cur_mode = 2'd0;
        do_reset();
        run(300, 1);
    endtask

    task automatic test_ext_passthrough();
        use_dut_a();
        cur_mode = 2'd0;
        do_reset();
        run(2 * 2 * PPF, 0);
    endtask

    task automatic test_checker();
        use_dut_a();
        cur_mode = 2'd1;
        do_reset();
        run(3 * 2 * PPF, 1);
    endtask

    task automatic test_mode_switch();
        use_dut_a();
        cur_mode = 2'd0;
        do_reset();
        run(2 * 40, 0);
        cur_mode = 2'd2;
        run(2 * 2 * PPF, 0);
    endtask

    task automatic test_grey();
        use_dut_a();
        cur_mode = 2'd3;
        do_reset();
        run(600, 1);
    endtask

    task automatic test_mid_reset();
        use_dut_a();
        cur_mode = 2'(($urandom_range(0, 3)));
        do_reset();
        run(2 * (2 * HT + 5), 1);
        do_reset();
        run(300, 1);
    endtask

    task automatic test_polarity_div1();
        which = 1; div = 1; hp = 1'b1; vp = 1'b1;
        cur_mode = 2'd1;
        do_reset();
        run(3 * PPF + 20, 1);
        cur_mode = 2'd2;
        run(2 * PPF, 0);
    endtask

    initial begin
        fb_a.i_red = '0; fb_a.i_green = '0; fb_a.i_blue = '0;
        fb_b.i_red = '0; fb_b.i_green = '0; fb_b.i_blue = '0;
        test_reset();
        test_sync_timing();
        test_ext_passthrough();
        test_checker();
        test_mode_switch();
        test_grey();
        test_mid_reset();
        test_polarity_div1();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
